uart_rx_8n1: RTL and testbench

- Serial receiver for the same 8N1 UART link that the board's transmitter drives: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), idle high.
- Oversamples `line_rx` with the system clock, samples each bit at mid-bit, and presents each received byte with a one-cycle valid strobe.
- Flags framing errors.
- Sits between the board RX pin and downstream command/loopback logic.

---
 rtl/uart_rx_8n1_if.sv | 11 +
 rtl/uart_rx_8n1.sv | 141 ++++++++++++++
 tb/tb_uart_rx_8n1.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_8n1_if.sv
// Serial receive bundle: RX pin in, received byte with valid/error strobes and busy out.
interface uart_rx_8n1_if;
  logic       line_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  modport master (output line_rx, input rx_data, rx_valid, frame_err, busy);
  modport slave  (input line_rx, output rx_data, rx_valid, frame_err, busy);
endinterface

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, valid/framing-error strobes.
// Optional UART_RX_MAJORITY_EN: 2-of-3 majority vote per bit, decided one cycle later.
module uart_rx_8n1 #(
  parameter int unsigned CLK_DIV  = 2500,
  parameter int unsigned HALF_DIV = CLK_DIV / 2
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_8n1_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned START_PT = HALF_DIV;
`else
  localparam int unsigned START_PT = HALF_DIV - 1;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       idx, idx_n;
  logic [7:0]       shreg, shreg_n;
  logic [7:0]       data_q, data_n;
  logic             valid_q, valid_n;
  logic             err_q, err_n;
  logic             busy_q, busy_n;
  logic             meta, rx_s, rx_s_d;
  logic             bit_val;
  logic             cnt_last;

  // Two flops for metastability, third for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      meta   <= bus.line_rx;
      rx_s   <= meta;
      rx_s_d <= rx_s;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  // Window of rx_s ending at the decision cycle: {two ago, one ago, now}
  always_ff @(posedge clk) begin
    if (rst) hist <= 2'b11;
    else     hist <= {hist[0], rx_s};
  end

  assign bit_val = (rx_s & hist[0]) | (rx_s & hist[1]) | (hist[0] & hist[1]);
`else
  assign bit_val = rx_s;
`endif

  assign cnt_last = (cnt == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      shreg   <= shreg_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      err_q   <= err_n;
      busy_q  <= busy_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt_last ? '0 : cnt + CNT_W'(1);
    idx_n   = idx;
    shreg_n = shreg;
    data_n  = data_q;
    valid_n = 1'b0;
    err_n   = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (rx_s_d && !rx_s) state_n = START;
      end
      START: begin
        if (cnt == CNT_W'(START_PT)) begin
          cnt_n = '0;
          idx_n = '0;
          // A high start sample means the falling edge was a glitch
          state_n = bit_val ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_last) begin
          shreg_n[idx] = bit_val;
          cnt_n        = '0;
          if (idx == 3'd7) state_n = STOP;
          else             idx_n   = idx + 3'd1;
        end
      end
      STOP: begin
        if (cnt_last) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (bit_val) begin
            data_n  = shreg;
            valid_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    // Busy stays up through the cycle the result strobe is visible
    busy_n = (state_n != IDLE) | valid_n | err_n;
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed self-checking bench for uart_rx_8n1 with CLK_DIV=16.
module tb_uart_rx_8n1;

  localparam int unsigned CLK_DIV  = 16;
  localparam int unsigned HALF_DIV = 8;
  // Line-drive cycle to strobe: 2 sync cycles + HALF_DIV + 9*CLK_DIV + 1
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT = 156;
`else
  localparam int LAT = 155;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   both = 0;

  logic [7:0] vq[$];
  int         vc[$];
  int         ec[$];

  uart_rx_8n1_if bus();

  uart_rx_8n1 #(.CLK_DIV(CLK_DIV), .HALF_DIV(HALF_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every strobe with its cycle number
  always @(negedge clk) begin
    if (bus.rx_valid) begin
      vq.push_back(bus.rx_data);
      vc.push_back(cyc);
    end
    if (bus.frame_err) ec.push_back(cyc);
    if (bus.rx_valid && bus.frame_err) both++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    vq.delete();
    vc.delete();
    ec.delete();
  endtask

  // Drive ncyc cycles of a frame; glitch_at inverts the line for one cycle
  task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch_at,
                            input int ncyc, output int k);
    logic [9:0] fr;
    logic       b;
    fr = {stop, d, 1'b0};
    k  = cyc;
    for (int i = 0; i < ncyc; i++) begin
      b = fr[i / int'(CLK_DIV)];
      if (i == glitch_at) b = ~b;
      bus.line_rx = b;
      step(1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.line_rx = 1'b1;
    step(3);
    @(negedge clk);
    tests++; if (bus.rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data got=%h exp=00", bus.rx_data); end
    tests++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid got=%b exp=0", bus.rx_valid); end
    tests++; if (bus.frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err got=%b exp=0", bus.frame_err); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    step(1);
    rst = 1'b0;
    clear_log();
    step(200);
    tests++; if (vq.size() != 0) begin fails++; $display("FAIL idle_valid_count got=%0d exp=0", vq.size()); end
    tests++; if (ec.size() != 0) begin fails++; $display("FAIL idle_err_count got=%0d exp=0", ec.size()); end
  endtask

  task automatic test_single_byte();
    int k;
    clear_log();
    send_frame(8'h49, 1'b1, -1, 160, k);
    step(20);
    tests++; if (vq.size() != 1) begin fails++; $display("FAIL single_valid_count got=%0d exp=1", vq.size()); end
    tests++; if (vq[0] !== 8'h49) begin fails++; $display("FAIL single_data got=%h exp=49", vq[0]); end
    tests++; if (vc[0] != k + LAT) begin fails++; $display("FAIL single_latency got=%0d exp=%0d", vc[0] - k, LAT); end
    tests++; if (ec.size() != 0) begin fails++; $display("FAIL single_err_count got=%0d exp=0", ec.size()); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL single_busy_after got=%b exp=0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    int k1, k2;
    clear_log();
    send_frame(8'h49, 1'b1, -1, 160, k1);
    send_frame(8'h30, 1'b1, -1, 160, k2);
    step(20);
    tests++; if (vq.size() != 2) begin fails++; $display("FAIL b2b_valid_count got=%0d exp=2", vq.size()); end
    tests++; if (vq[0] !== 8'h49) begin fails++; $display("FAIL b2b_data0 got=%h exp=49", vq[0]); end
    tests++; if (vq[1] !== 8'h30) begin fails++; $display("FAIL b2b_data1 got=%h exp=30", vq[1]); end
    tests++; if (vc[0] != k1 + LAT) begin fails++; $display("FAIL b2b_latency0 got=%0d exp=%0d", vc[0] - k1, LAT); end
    tests++; if (vc[1] - vc[0] != 160) begin fails++; $display("FAIL b2b_spacing got=%0d exp=160", vc[1] - vc[0]); end
    tests++; if (ec.size() != 0) begin fails++; $display("FAIL b2b_err_count got=%0d exp=0", ec.size()); end
  endtask

  task automatic test_frame_err();
    int k;
    clear_log();
    send_frame(8'hA5, 1'b0, -1, 160, k);
    bus.line_rx = 1'b1;
    step(20);
    tests++; if (ec.size() != 1) begin fails++; $display("FAIL ferr_err_count got=%0d exp=1", ec.size()); end
    tests++; if (ec[0] != k + LAT) begin fails++; $display("FAIL ferr_latency got=%0d exp=%0d", ec[0] - k, LAT); end
    tests++; if (vq.size() != 0) begin fails++; $display("FAIL ferr_valid_count got=%0d exp=0", vq.size()); end
    tests++; if (bus.rx_data !== 8'h30) begin fails++; $display("FAIL ferr_data_held got=%h exp=30", bus.rx_data); end
  endtask

  task automatic test_break();
    int k;
    clear_log();
    k = cyc;
    bus.line_rx = 1'b0;
    step(200);
    bus.line_rx = 1'b1;
    step(200);
    tests++; if (ec.size() != 1) begin fails++; $display("FAIL break_err_count got=%0d exp=1", ec.size()); end
    tests++; if (ec[0] != k + LAT) begin fails++; $display("FAIL break_latency got=%0d exp=%0d", ec[0] - k, LAT); end
    tests++; if (vq.size() != 0) begin fails++; $display("FAIL break_valid_count got=%0d exp=0", vq.size()); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL break_busy_after got=%b exp=0", bus.busy); end
  endtask

  task automatic test_glitch();
    int k;
    clear_log();
    k = cyc;
    bus.line_rx = 1'b0;
    step(4);
    bus.line_rx = 1'b1;
    while (cyc < k + 4) @(posedge clk);
    @(negedge clk);
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL glitch_busy_rise got=%b exp=1", bus.busy); end
    while (cyc < k + 12) @(posedge clk);
    @(negedge clk);
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL glitch_busy_fall got=%b exp=0", bus.busy); end
    step(200);
    tests++; if (vq.size() != 0) begin fails++; $display("FAIL glitch_valid_count got=%0d exp=0", vq.size()); end
    tests++; if (ec.size() != 0) begin fails++; $display("FAIL glitch_err_count got=%0d exp=0", ec.size()); end
  endtask

`ifdef UART_RX_MAJORITY_EN
  task automatic test_majority_glitch();
    int k;
    clear_log();
    // One-cycle high spike centred on the data bit 3 sampling window
    send_frame(8'h00, 1'b1, 72, 160, k);
    step(20);
    tests++; if (vq.size() != 1) begin fails++; $display("FAIL maj_valid_count got=%0d exp=1", vq.size()); end
    tests++; if (vq[0] !== 8'h00) begin fails++; $display("FAIL maj_data got=%h exp=00", vq[0]); end
    tests++; if (vc[0] != k + LAT) begin fails++; $display("FAIL maj_latency got=%0d exp=%0d", vc[0] - k, LAT); end
  endtask
`endif

  task automatic test_reset_mid_frame();
    int k;
    clear_log();
    send_frame(8'hFF, 1'b1, -1, 88, k);
    rst = 1'b1;
    step(3);
    @(negedge clk);
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    step(1);
    rst = 1'b0;
    bus.line_rx = 1'b1;
    step(100);
    send_frame(8'h5A, 1'b1, -1, 160, k);
    step(20);
    tests++; if (vq.size() != 1) begin fails++; $display("FAIL midrst_valid_count got=%0d exp=1", vq.size()); end
    tests++; if (vq[0] !== 8'h5A) begin fails++; $display("FAIL midrst_data got=%h exp=5a", vq[0]); end
    tests++; if (vc[0] != k + LAT) begin fails++; $display("FAIL midrst_latency got=%0d exp=%0d", vc[0] - k, LAT); end
    tests++; if (ec.size() != 0) begin fails++; $display("FAIL midrst_err_count got=%0d exp=0", ec.size()); end
  endtask

  initial begin
    bus.line_rx = 1'b1;
    step(1);
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_break();
    test_reset_mid_frame();
`ifdef UART_RX_MAJORITY_EN
    test_majority_glitch();
`endif
    tests++; if (both != 0) begin fails++; $display("FAIL valid_err_overlap got=%0d exp=0", both); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
